// File: rtl/sig_control_multi.sv
// sig_control_multi
//   Main-road / multi-side-road traffic signal controller (Moore FSM).
//   The main road rests on GREEN. When any side road requests, one road is
//   chosen round-robin, the main road goes through YELLOW and an all-RED gap,
//   and the chosen side road gets GREEN until its request drops or the
//   maximum green time expires. It then shows YELLOW and control returns to
//   the main road.
//
// Ports
//   CLOCK           in   system clock, rising edge active
//   CLEAR           in   asynchronous active-low reset
//   CAR_ON_SIDE_RD  in   [N_SIDE]   bit i high = car waiting on side road i
//   MAIN_SIG        out  [2]        main-road lamp (0 RED, 1 YELLOW, 2 GREEN)
//   SIDE_SIG        out  [2*N_SIDE] side-road lamps, road i at [2i+1:2i]
//   SEL_IDX         out  [clog2(N_SIDE)] side road granted or committed
module sig_control_multi #(
  parameter int unsigned N_SIDE         = 2,
  parameter int unsigned Y2RDELAY       = 3,
  parameter int unsigned R2GDELAY       = 2,
  parameter int unsigned MAIN_MIN_GREEN = 4,
  parameter int unsigned SIDE_MAX_GREEN = 8
) (
  input  logic                      CLOCK,
  input  logic                      CLEAR,
  input  logic [N_SIDE-1:0]         CAR_ON_SIDE_RD,
  output logic [1:0]                MAIN_SIG,
  output logic [2*N_SIDE-1:0]       SIDE_SIG,
  output logic [$clog2(N_SIDE)-1:0] SEL_IDX
);

  localparam int unsigned SW   = $clog2(N_SIDE);
  localparam int unsigned D1   = (Y2RDELAY > R2GDELAY) ? Y2RDELAY : R2GDELAY;
  localparam int unsigned D2   = (MAIN_MIN_GREEN > SIDE_MAX_GREEN) ? MAIN_MIN_GREEN : SIDE_MAX_GREEN;
  localparam int unsigned DMAX = (D1 > D2) ? D1 : D2;
  // Wide enough that the saturated value always exceeds every threshold.
  localparam int unsigned CW   = $clog2(DMAX + 1);

  localparam logic [CW-1:0] Y2R_LAST  = CW'(Y2RDELAY - 1);
  localparam logic [CW-1:0] R2G_LAST  = CW'(R2GDELAY - 1);
  localparam logic [CW-1:0] MING_LAST = CW'(MAIN_MIN_GREEN - 1);
  localparam logic [CW-1:0] MAXG_LAST = CW'(SIDE_MAX_GREEN - 1);

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [2:0] {
    MAIN_GREEN,
    MAIN_YELLOW,
    ALL_RED,
    SIDE_GREEN,
    SIDE_YELLOW
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   pick;
  logic [SW-1:0]   idx;
  logic [SW-1:0]   next_ptr;
  logic            found;
  logic [1:0]      side_lamp;

  // Round-robin search: first requesting road starting at ptr, wrapping.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_SIDE; i++) begin
      idx = SW'((32'(ptr) + i) % N_SIDE);
      if (!found && CAR_ON_SIDE_RD[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign next_ptr = SW'((32'(SEL_IDX) + 1) % N_SIDE);

  always_comb begin
    state_n = state;
    case (state)
      MAIN_GREEN:  if (cnt >= MING_LAST && found)                          state_n = MAIN_YELLOW;
      MAIN_YELLOW: if (cnt >= Y2R_LAST)                                    state_n = ALL_RED;
      ALL_RED:     if (cnt >= R2G_LAST)                                    state_n = SIDE_GREEN;
      SIDE_GREEN:  if (!CAR_ON_SIDE_RD[SEL_IDX] || cnt >= MAXG_LAST)       state_n = SIDE_YELLOW;
      SIDE_YELLOW: if (cnt >= Y2R_LAST)                                    state_n = MAIN_GREEN;
      default:                                                             state_n = MAIN_GREEN;
    endcase
  end

  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      state   <= MAIN_GREEN;
      cnt     <= '0;
      ptr     <= '0;
      SEL_IDX <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CW'(1);
      // SEL_IDX is only committed when leaving main green; the pointer
      // advances past the served road when the side sequence finishes.
      if (state == MAIN_GREEN && state_n == MAIN_YELLOW)
        SEL_IDX <= pick;
      if (state == SIDE_YELLOW && state_n == MAIN_GREEN)
        ptr <= next_ptr;
    end
  end

  always_comb begin
    MAIN_SIG  = RED;
    SIDE_SIG  = {N_SIDE{RED}};
    side_lamp = RED;
    case (state)
      MAIN_GREEN:  MAIN_SIG  = GREEN;
      MAIN_YELLOW: MAIN_SIG  = YELLOW;
      SIDE_GREEN:  side_lamp = GREEN;
      SIDE_YELLOW: side_lamp = YELLOW;
      default:     MAIN_SIG  = RED;
    endcase
    for (int unsigned i = 0; i < N_SIDE; i++) begin
      if (SW'(i) == SEL_IDX)
        SIDE_SIG[2*i +: 2] = side_lamp;
    end
  end

endmodule

// File: doc/sig_control_multi.md
SIG_CONTROL_MULTI -- requirements
Module: sig_control_multi

Interface
REQ-001 The block SHALL have parameter N_SIDE, default 2, number of side (country) roads; legal range 2..8.
REQ-002 The block SHALL have parameter Y2RDELAY, default 3, yellow duration in cycles; legal range >=1.
REQ-003 The block SHALL have parameter R2GDELAY, default 2, all-red duration in cycles; legal range >=1.
REQ-004 The block SHALL have parameter MAIN_MIN_GREEN, default 4, minimum main-road green in cycles; legal range >=1.
REQ-005 The block SHALL have parameter SIDE_MAX_GREEN, default 8, maximum side-road green in cycles; legal range >=1.
REQ-006 The block SHALL have port CLOCK  input  1  system clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port CLEAR  input  1  reset, asynchronous and active-low.
REQ-008 The block SHALL have port CAR_ON_SIDE_RD  input  N_SIDE  bit i high = car waiting on side road i.
REQ-009 The block SHALL have port MAIN_SIG  output  2  main-road signal.
REQ-010 The block SHALL have port SIDE_SIG  output  2*N_SIDE  side-road signals, road i at bits [2i+1:2i].
REQ-011 The block SHALL have port SEL_IDX  output  $clog2(N_SIDE)  index of the side road currently granted or committed.
REQ-012 Signal encoding SHALL be RED=2'd0, YELLOW=2'd1, GREEN=2'd2; 2'd3 SHALL never be driven.

Function
REQ-013 The controller SHALL be a Moore FSM with states MAIN_GREEN, MAIN_YELLOW, ALL_RED, SIDE_GREEN and SIDE_YELLOW; outputs SHALL be decoded from registered state only.
REQ-014 A dwell counter SHALL clear to 0 on every state transition, increment each cycle otherwise, and saturate at its maximum with no wrap.
REQ-015 MAIN_GREEN: MAIN_SIG=GREEN, all SIDE_SIG=RED; it SHALL go to MAIN_YELLOW at the first edge where counter>=MAIN_MIN_GREEN-1 and CAR_ON_SIDE_RD!=0; with no requests it SHALL stay indefinitely.
REQ-016 On the MAIN_GREEN->MAIN_YELLOW edge, SEL_IDX SHALL load the first requesting road searching from round-robin pointer PTR upward modulo N_SIDE (PTR itself first).
REQ-017 MAIN_YELLOW: MAIN_SIG=YELLOW, sides RED, exactly Y2RDELAY cycles, then ALL_RED.
REQ-018 ALL_RED: all signals RED, exactly R2GDELAY cycles, then SIDE_GREEN.
REQ-019 SIDE_GREEN: SIDE_SIG[SEL_IDX]=GREEN, MAIN_SIG=RED, other sides RED; at least 1 cycle; it SHALL go to SIDE_YELLOW at the first edge where CAR_ON_SIDE_RD[SEL_IDX]=0 or counter=SIDE_MAX_GREEN-1.
REQ-020 SIDE_YELLOW: SIDE_SIG[SEL_IDX]=YELLOW, MAIN_SIG=RED, exactly Y2RDELAY cycles, then MAIN_GREEN, with PTR<=(SEL_IDX+1) mod N_SIDE on that edge.
REQ-021 Once MAIN_YELLOW is entered the sequence SHALL complete through SIDE_YELLOW even if all requests drop; a withdrawn request yields a 1-cycle SIDE_GREEN.
REQ-022 Requests on non-selected roads SHALL be ignored until the next MAIN_GREEN; SEL_IDX SHALL hold its value outside the MAIN_GREEN->MAIN_YELLOW edge.
REQ-023 At most one road (main or one side) SHALL be non-RED in any cycle.

Reset
REQ-024 CLEAR low SHALL immediately, regardless of clock or state, force state=MAIN_GREEN, counter=0, PTR=0, SEL_IDX=0, MAIN_SIG=GREEN, SIDE_SIG=all RED.
REQ-025 After CLEAR deasserts, the first dwell cycle SHALL count from the first rising edge with CLEAR high.

Verification (defaults N_SIDE=2, Y2R=3, R2G=2, MIN=4, MAX=8)
REQ-026 Idle: CLEAR released, CAR_ON_SIDE_RD=00 for 100 cycles -> MAIN_SIG=2 throughout, SIDE_SIG=0000, no counter wrap.
REQ-027 Single request: CAR_ON_SIDE_RD=01 held from release -> MAIN green 4 cycles, yellow 3, all-red 2, SIDE_SIG=0010 while held; drop -> SIDE_SIG=0001 for 3 cycles, then MAIN_SIG=2.
REQ-028 Max green: CAR_ON_SIDE_RD=01 held forever -> SIDE_SIG[1:0]=GREEN exactly 8 cycles, yellow 3, then MAIN green >=4 cycles before road 0 is re-served.
REQ-029 Round-robin: CAR_ON_SIDE_RD=11 held -> SEL_IDX sequence 0,1,0,1; MAIN green 4 cycles between each side service.
REQ-030 Withdrawn request: CAR_ON_SIDE_RD=10 for 5 cycles then 00 during MAIN_YELLOW -> sequence completes, SIDE_SIG=1000 for exactly 1 cycle, then yellow 3 cycles.
REQ-031 Reset mid-operation: CLEAR low between edges during SIDE_GREEN -> MAIN_SIG=2, SIDE_SIG=0000, SEL_IDX=0 without waiting for a clock edge; after release, behaviour matches the post-reset case.
